// File: rtl/harvos_dma_copy_engine.sv
// harvos_dma_copy_engine: single-channel word copy engine that masters the
// DMA firewall's dmem port. Alternates one read and one write per word, with
// fault / timeout / abort reporting through STATUS, ERR_ADDR and irq.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no transfer; waits for START
// S_RD    | read word at cur_src; dma_req raised one cycle after entry
// S_WR    | write data_q to cur_dst; decides done / abort / next word
module harvos_dma_copy_engine #(
    parameter int LEN_W       = 16,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_en,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    output logic        irq,
    output logic        dma_req,
    output logic        dma_we,
    output logic [3:0]  dma_be,
    output logic [31:0] dma_addr,
    output logic [31:0] dma_wdata,
    input  logic [31:0] dma_rdata,
    input  logic        dma_done,
    input  logic        dma_fault
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    // Response timer is a down-counter loaded at each request; terminal count
    // 0 on a cycle with no dma_done means TIMEOUT_CYC request cycles elapsed.
    localparam int             TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = (TIMEOUT_CYC > 0) ? TMO_W'(TIMEOUT_CYC - 1) : '0;
    localparam bit             TMO_ON   = (TIMEOUT_CYC > 0);

    logic [1:0]       state;
    logic [31:0]      src_q, dst_q, cur_src, cur_dst, data_q, err_addr;
    logic [LEN_W-1:0] len_q, remain;
    logic             ie_q, done_q, err_q, abort_pending;
    logic [1:0]       err_code;
    logic [TMO_W-1:0] tmo_cnt;

    logic cfg_wr, start_cmd, abort_cmd, busy, tmo_hit;

    assign cfg_wr    = cfg_en & cfg_we;
    assign start_cmd = cfg_wr && (cfg_addr == 4'd0) && cfg_wdata[0];
    assign abort_cmd = cfg_wr && (cfg_addr == 4'd0) && cfg_wdata[1];
    assign busy      = (state != S_IDLE);
    assign tmo_hit   = TMO_ON && dma_req && !dma_done && (tmo_cnt == '0);
    assign irq       = (done_q | err_q) & ie_q;
    assign dma_be    = 4'hF;

    // Register file writes followed by the transfer FSM; hardware updates are
    // placed after the config writes so a same-cycle hardware set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            src_q         <= '0;
            dst_q         <= '0;
            len_q         <= '0;
            ie_q          <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            err_code      <= 2'd0;
            err_addr      <= '0;
            cur_src       <= '0;
            cur_dst       <= '0;
            remain        <= '0;
            data_q        <= '0;
            abort_pending <= 1'b0;
            tmo_cnt       <= '0;
            dma_req       <= 1'b0;
            dma_we        <= 1'b0;
            dma_addr      <= '0;
            dma_wdata     <= '0;
        end else begin
            if (cfg_wr) begin
                case (cfg_addr)
                    4'd0: ie_q <= cfg_wdata[2];
                    4'd1: if (!busy) src_q <= {cfg_wdata[31:2], 2'b00};
                    4'd2: if (!busy) dst_q <= {cfg_wdata[31:2], 2'b00};
                    4'd3: if (!busy) len_q <= cfg_wdata[LEN_W-1:0];
                    4'd4: begin
                        if (cfg_wdata[1]) done_q <= 1'b0;
                        if (cfg_wdata[2]) begin
                            err_q    <= 1'b0;
                            err_code <= 2'd0;
                        end
                    end
                    default: ;
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (start_cmd) begin
                        if (len_q != '0) begin
                            cur_src  <= src_q;
                            cur_dst  <= dst_q;
                            remain   <= len_q;
                            done_q   <= 1'b0;
                            err_q    <= 1'b0;
                            err_code <= 2'd0;
                            state    <= S_RD;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_RD, S_WR: begin
                    if (abort_cmd) abort_pending <= 1'b1;
                    if (!dma_req) begin
                        // first cycle in a state: present fresh fields with the request
                        dma_req  <= 1'b1;
                        dma_we   <= (state == S_WR);
                        dma_addr <= (state == S_WR) ? cur_dst : cur_src;
                        if (state == S_WR) dma_wdata <= data_q;
                        tmo_cnt  <= TMO_LOAD;
                    end else if (dma_done) begin
                        dma_req <= 1'b0;
                        if (dma_fault) begin
                            err_q         <= 1'b1;
                            err_code      <= (state == S_WR) ? 2'd2 : 2'd1;
                            err_addr      <= dma_addr;
                            abort_pending <= 1'b0;
                            state         <= S_IDLE;
                        end else if (state == S_RD) begin
                            data_q <= dma_rdata;
                            state  <= S_WR;
                        end else begin
                            cur_src <= cur_src + 32'd4;
                            cur_dst <= cur_dst + 32'd4;
                            remain  <= remain - LEN_W'(1);
                            if (remain == LEN_W'(1)) begin
                                done_q        <= 1'b1;
                                abort_pending <= 1'b0;
                                state         <= S_IDLE;
                            end else if (abort_pending) begin
                                err_q         <= 1'b1;
                                err_code      <= 2'd3;
                                abort_pending <= 1'b0;
                                state         <= S_IDLE;
                            end else begin
                                state <= S_RD;
                            end
                        end
                    end else if (tmo_hit) begin
                        dma_req       <= 1'b0;
                        err_q         <= 1'b1;
                        err_code      <= 2'd3;
                        err_addr      <= dma_addr;
                        abort_pending <= 1'b0;
                        state         <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Config read mux, combinational on cfg_addr.
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            4'd0: cfg_rdata = {29'b0, ie_q, 2'b00};
            4'd1: cfg_rdata = src_q;
            4'd2: cfg_rdata = dst_q;
            4'd3: cfg_rdata = 32'(len_q);
            4'd4: cfg_rdata = {27'b0, err_code, err_q, done_q, busy};
            4'd5: cfg_rdata = err_addr;
            4'd6: cfg_rdata = 32'(remain);
            default: cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_harvos_dma_copy_engine.sv
// Bench for harvos_dma_copy_engine: a memory slave with programmable latency,
// fault address and mute, plus a word-by-word copy model for expectations.
module tb_harvos_dma_copy_engine;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clk, rst, cfg_en, cfg_we;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata, cfg_rdata;
    logic        irq, dma_req, dma_we, dma_done, dma_fault;
    logic [3:0]  dma_be;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [logic [31:0]];
    txn_t        act_q[$];
    txn_t        exp_q[$];
    int          slave_delay;
    bit          slave_mute, fault_en, fault_we;
    logic [31:0] fault_addr;
    int          late_req, late_seen;

    harvos_dma_copy_engine #(.LEN_W(16), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .irq(irq), .dma_req(dma_req),
        .dma_we(dma_we), .dma_be(dma_be), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_done(dma_done), .dma_fault(dma_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // Slave: answers each request after slave_delay cycles, logs every transaction.
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        late_seen = 0;
        dma_done  = 1'b0;
        dma_fault = 1'b0;
        dma_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            dma_done  = 1'b0;
            dma_fault = 1'b0;
            if (late_req != late_seen) begin
                late_seen = late_req;
                dma_done  = 1'b1;
            end else if (dma_req && !slave_mute) begin
                if (wait_cnt >= slave_delay) begin
                    wait_cnt  = 0;
                    dma_done  = 1'b1;
                    dma_fault = fault_en && (dma_we == fault_we) && (dma_addr == fault_addr);
                    dma_rdata = dma_we ? $urandom : mem_val(dma_addr);
                    act_q.push_back(txn_t'({dma_we, dma_addr, dma_we ? dma_wdata : dma_rdata}));
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic cfg_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_en = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_en = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic cfg_rd(input logic [3:0] a, output logic [31:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] s;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cfg_rd(4'd4, s);
            if (!s[0]) return;
        end
    endtask

    task automatic program_xfer(input logic [31:0] src, input logic [31:0] dst, input int len);
        cfg_wr(4'd1, src);
        cfg_wr(4'd2, dst);
        cfg_wr(4'd3, 32'(len));
    endtask

    // Reference: word i is read from src+4i then written to dst+4i; a fault
    // stops before any count change, an abort is honoured after word abort_word.
    task automatic model_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                              input int abort_word, output logic [1:0] ec,
                              output logic [31:0] ea, output int rem, output logic dn);
        logic [31:0] ra, wa;
        exp_q.delete();
        ec = 2'd0; ea = '0; rem = len; dn = 1'b0;
        for (int i = 0; i < len; i++) begin
            ra = src + 32'(4 * i);
            wa = dst + 32'(4 * i);
            exp_q.push_back(txn_t'({1'b0, ra, mem_val(ra)}));
            if (fault_en && !fault_we && fault_addr == ra) begin ec = 2'd1; ea = ra; return; end
            exp_q.push_back(txn_t'({1'b1, wa, mem_val(ra)}));
            if (fault_en && fault_we && fault_addr == wa) begin ec = 2'd2; ea = wa; return; end
            rem = len - i - 1;
            if (rem == 0) begin dn = 1'b1; return; end
            if (abort_word == i + 1) begin ec = 2'd3; return; end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        checks++; if (dma_req !== 1'b0)  begin errors++; $display("FAIL rst_req got %b exp 0", dma_req); end
        checks++; if (dma_we !== 1'b0)   begin errors++; $display("FAIL rst_we got %b exp 0", dma_we); end
        checks++; if (dma_be !== 4'hF)   begin errors++; $display("FAIL rst_be got %h exp f", dma_be); end
        checks++; if (dma_addr !== '0)   begin errors++; $display("FAIL rst_addr got %h exp 0", dma_addr); end
        checks++; if (dma_wdata !== '0)  begin errors++; $display("FAIL rst_wdata got %h exp 0", dma_wdata); end
        checks++; if (irq !== 1'b0)      begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            cfg_rd(4'(a), d);
            checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL rst_reg%0d got %h exp 0", a, d); end
        end
    endtask

    task automatic test_basic_copy();
        logic [31:0] s, r, ea; logic [1:0] ec; int rem, base; logic dn;
        mem[32'h1000] = 32'hA0; mem[32'h1004] = 32'hA1; mem[32'h1008] = 32'hA2;
        slave_delay = 2; fault_en = 1'b0;
        program_xfer(32'h1000, 32'h2000, 3);
        model_copy(32'h1000, 32'h2000, 3, 0, ec, ea, rem, dn);
        base = act_q.size();
        cfg_wr(4'd0, 32'h5);
        wait_idle(400);
        @(negedge clk);
        cfg_rd(4'd4, s); cfg_rd(4'd6, r);
        checks++; if (s !== 32'h2) begin errors++; $display("FAIL basic_status got %h exp 2", s); end
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL basic_remain got %h exp 0", r); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq got %b exp 1", irq); end
        checks++;
        if (act_q.size() - base != 6) begin errors++; $display("FAIL basic_count got %0d exp 6", act_q.size() - base); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (base + i >= act_q.size()) begin errors++; $display("FAIL basic_txn%0d got none exp %h", i, exp_q[i]); end
            else if (act_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL basic_txn%0d got %h exp %h", i, act_q[base+i], exp_q[i]); end
        end
        if (act_q.size() - base >= 6) begin
            checks++;
            if (act_q[base+5] !== txn_t'({1'b1, 32'h2008, 32'hA2}))
                begin errors++; $display("FAIL basic_lastwr got %h exp 1_00002008_000000a2", act_q[base+5]); end
        end
        cfg_wr(4'd4, 32'h2);
        cfg_rd(4'd4, s);
        checks++; if (s !== 32'h0) begin errors++; $display("FAIL basic_clr got %h exp 0", s); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_clr_irq got %b exp 0", irq); end
    endtask

    task automatic test_write_fault();
        logic [31:0] s, e, r, ea; logic [1:0] ec; int rem, base; logic dn;
        slave_delay = 1; fault_en = 1'b1; fault_we = 1'b1; fault_addr = 32'h100;
        program_xfer(32'h3000, 32'h0000_0100, 2);
        model_copy(32'h3000, 32'h100, 2, 0, ec, ea, rem, dn);
        base = act_q.size();
        cfg_wr(4'd0, 32'h1);
        wait_idle(400);
        repeat (10) @(negedge clk);
        cfg_rd(4'd4, s); cfg_rd(4'd5, e); cfg_rd(4'd6, r);
        checks++; if (s !== 32'h14) begin errors++; $display("FAIL wfault_status got %h exp 14", s); end
        checks++; if (e !== 32'h100) begin errors++; $display("FAIL wfault_erraddr got %h exp 100", e); end
        checks++; if (r !== 32'(rem)) begin errors++; $display("FAIL wfault_remain got %h exp %h", r, rem); end
        checks++;
        if (act_q.size() - base != exp_q.size()) begin errors++; $display("FAIL wfault_count got %0d exp %0d", act_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (base + i >= act_q.size()) begin errors++; $display("FAIL wfault_txn%0d got none exp %h", i, exp_q[i]); end
            else if (act_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL wfault_txn%0d got %h exp %h", i, act_q[base+i], exp_q[i]); end
        end
        checks++; if (dma_req !== 1'b0) begin errors++; $display("FAIL wfault_req got %b exp 0", dma_req); end
        fault_en = 1'b0;
    endtask

    task automatic test_len_zero();
        logic [31:0] s; int base, n;
        cfg_wr(4'd4, 32'h6);
        cfg_wr(4'd3, 32'h0);
        base = act_q.size();
        cfg_wr(4'd0, 32'h1);
        cfg_rd(4'd4, s);
        checks++; if (s !== 32'h2) begin errors++; $display("FAIL len0_status got %h exp 2", s); end
        n = 0;
        repeat (6) begin @(negedge clk); if (dma_req) n++; end
        checks++; if (n != 0) begin errors++; $display("FAIL len0_req got %0d cycles exp 0", n); end
        checks++; if (act_q.size() != base) begin errors++; $display("FAIL len0_txn got %0d exp 0", act_q.size() - base); end
    endtask

    task automatic test_abort();
        logic [31:0] s, r, ea; logic [1:0] ec; int rem, base; logic dn;
        slave_delay = 3;
        program_xfer(32'h4000, 32'h5000, 5);
        model_copy(32'h4000, 32'h5000, 5, 2, ec, ea, rem, dn);
        base = act_q.size();
        cfg_wr(4'd0, 32'h1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dma_req && !dma_we && dma_addr == 32'h4004) break;
        end
        cfg_wr(4'd0, 32'h2);
        wait_idle(400);
        repeat (5) @(negedge clk);
        cfg_rd(4'd4, s); cfg_rd(4'd6, r);
        checks++; if (s !== 32'h1C) begin errors++; $display("FAIL abort_status got %h exp 1c", s); end
        checks++; if (r !== 32'h3) begin errors++; $display("FAIL abort_remain got %h exp 3", r); end
        checks++;
        if (act_q.size() - base != 4) begin errors++; $display("FAIL abort_count got %0d exp 4", act_q.size() - base); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (base + i >= act_q.size()) begin errors++; $display("FAIL abort_txn%0d got none exp %h", i, exp_q[i]); end
            else if (act_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL abort_txn%0d got %h exp %h", i, act_q[base+i], exp_q[i]); end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] s, e; int n, base; bit seen;
        slave_mute = 1'b1;
        program_xfer(32'h6000, 32'h6100, 1);
        base = act_q.size();
        cfg_wr(4'd0, 32'h1);
        n = 0; seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (dma_req) begin n++; seen = 1'b1; end
            else if (seen) break;
        end
        checks++; if (n != 8) begin errors++; $display("FAIL tmo_reqlen got %0d exp 8", n); end
        cfg_rd(4'd4, s); cfg_rd(4'd5, e);
        checks++; if (s !== 32'h1C) begin errors++; $display("FAIL tmo_status got %h exp 1c", s); end
        checks++; if (e !== 32'h6000) begin errors++; $display("FAIL tmo_erraddr got %h exp 6000", e); end
        late_req++;
        n = 0;
        repeat (4) begin @(negedge clk); if (dma_req) n++; end
        cfg_rd(4'd4, s);
        checks++; if (s !== 32'h1C) begin errors++; $display("FAIL tmo_late_status got %h exp 1c", s); end
        checks++; if (n != 0) begin errors++; $display("FAIL tmo_late_req got %0d exp 0", n); end
        checks++; if (act_q.size() != base) begin errors++; $display("FAIL tmo_txn got %0d exp 0", act_q.size() - base); end
        slave_mute = 1'b0;
    endtask

    task automatic test_wrap_busy();
        logic [31:0] s, l, ea; logic [1:0] ec; int rem, base; logic dn;
        slave_delay = 3;
        program_xfer(32'hFFFF_FFFC, 32'h7000, 2);
        model_copy(32'hFFFF_FFFC, 32'h7000, 2, 0, ec, ea, rem, dn);
        base = act_q.size();
        cfg_wr(4'd0, 32'h1);
        cfg_wr(4'd1, 32'h1234);
        cfg_wr(4'd0, 32'h1);
        cfg_wr(4'd3, 32'h9);
        cfg_rd(4'd1, s); cfg_rd(4'd3, l);
        checks++; if (s !== 32'hFFFF_FFFC) begin errors++; $display("FAIL busy_src got %h exp fffffffc", s); end
        checks++; if (l !== 32'h2) begin errors++; $display("FAIL busy_len got %h exp 2", l); end
        wait_idle(400);
        repeat (10) @(negedge clk);
        cfg_rd(4'd4, s);
        checks++; if (s !== 32'h2) begin errors++; $display("FAIL wrap_status got %h exp 2", s); end
        checks++;
        if (act_q.size() - base != 4) begin errors++; $display("FAIL wrap_count got %0d exp 4", act_q.size() - base); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (base + i >= act_q.size()) begin errors++; $display("FAIL wrap_txn%0d got none exp %h", i, exp_q[i]); end
            else if (act_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL wrap_txn%0d got %h exp %h", i, act_q[base+i], exp_q[i]); end
        end
        if (act_q.size() - base >= 3) begin
            checks++;
            if (act_q[base+2].addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 0", act_q[base+2].addr); end
        end
    endtask

    task automatic test_random();
        logic [31:0] src, dst, s, r, e, ea; logic [1:0] ec; int rem, base, len, k; logic dn; bit ie;
        for (int it = 0; it < 16; it++) begin
            src = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            dst = $urandom & 32'hFFFF_FFFC;
            len = $urandom_range(1, 6);
            slave_delay = $urandom_range(0, 4);
            fault_en = ($urandom_range(0, 2) == 0);
            fault_we = $urandom_range(0, 1);
            k = $urandom_range(0, len - 1);
            fault_addr = fault_we ? dst + 32'(4 * k) : src + 32'(4 * k);
            ie = $urandom_range(0, 1);
            program_xfer(src, dst, len);
            model_copy(src, dst, len, 0, ec, ea, rem, dn);
            base = act_q.size();
            cfg_wr(4'd0, {29'b0, ie, 2'b01});
            wait_idle(400);
            @(negedge clk);
            cfg_rd(4'd4, s); cfg_rd(4'd6, r); cfg_rd(4'd5, e);
            checks++;
            if (s !== {27'b0, ec, (ec != 2'd0), dn, 1'b0}) begin errors++; $display("FAIL rnd%0d_status got %h exp %h", it, s, {27'b0, ec, (ec != 2'd0), dn, 1'b0}); end
            checks++; if (r !== 32'(rem)) begin errors++; $display("FAIL rnd%0d_remain got %h exp %h", it, r, rem); end
            checks++; if (irq !== ie) begin errors++; $display("FAIL rnd%0d_irq got %b exp %b", it, irq, ie); end
            if (ec == 2'd1 || ec == 2'd2) begin
                checks++; if (e !== ea) begin errors++; $display("FAIL rnd%0d_erraddr got %h exp %h", it, e, ea); end
            end
            checks++;
            if (act_q.size() - base != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count got %0d exp %0d", it, act_q.size() - base, exp_q.size()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (base + i >= act_q.size()) begin errors++; $display("FAIL rnd%0d_txn%0d got none exp %h", it, i, exp_q[i]); end
                else if (act_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_txn%0d got %h exp %h", it, i, act_q[base+i], exp_q[i]); end
            end
        end
        fault_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] s, r, c, a;
        slave_delay = 1;
        program_xfer(32'h8000, 32'h9000, 40);
        cfg_wr(4'd0, 32'h5);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cfg_rd(4'd4, s); cfg_rd(4'd6, r); cfg_rd(4'd0, c); cfg_rd(4'd1, a);
        checks++; if (s !== 32'h0) begin errors++; $display("FAIL rstmid_status got %h exp 0", s); end
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL rstmid_remain got %h exp 0", r); end
        checks++; if (c !== 32'h0) begin errors++; $display("FAIL rstmid_ctrl got %h exp 0", c); end
        checks++; if (a !== 32'h0) begin errors++; $display("FAIL rstmid_src got %h exp 0", a); end
        checks++; if (dma_req !== 1'b0) begin errors++; $display("FAIL rstmid_req got %b exp 0", dma_req); end
        checks++; if (dma_addr !== '0) begin errors++; $display("FAIL rstmid_addr got %h exp 0", dma_addr); end
    endtask

    initial begin
        rst = 1'b1; cfg_en = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        slave_delay = 2; slave_mute = 1'b0; fault_en = 1'b0; fault_we = 1'b0;
        fault_addr = '0; late_req = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_basic_copy();
        test_write_fault();
        test_len_zero();
        test_abort();
        test_timeout();
        test_wrap_busy();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
